// File: rtl/corr_win_pkg.sv
// Shared types and constants for the correlation window sequencer.
package corr_win_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_SETTLE,
    ST_PRESENT,
    ST_FLUSH
  } win_state_t;

  localparam int CORR_WIN_DEPTH = 17;
  localparam int NIBBLE_W       = 4;
  localparam int WIN_COUNT_W    = 16;

endpackage

// File: rtl/corr_window_ctrl_if.sv
// Control, symbol stream, shift-register write and window handshake bundle.
interface corr_window_ctrl_if;
  import corr_win_pkg::*;

  logic                   start;
  logic                   flush;
  logic                   in_valid;
  logic [NIBBLE_W-1:0]    in_data;
  logic                   in_ready;
  logic                   sr_we;
  logic [NIBBLE_W-1:0]    sr_wdata;
  logic                   win_valid;
  logic                   win_ack;
  logic                   busy;
  logic [WIN_COUNT_W-1:0] win_count;

  modport master (
    output start, flush, in_valid, in_data, win_ack,
    input  in_ready, sr_we, sr_wdata, win_valid, busy, win_count
  );

  modport slave (
    input  start, flush, in_valid, in_data, win_ack,
    output in_ready, sr_we, sr_wdata, win_valid, busy, win_count
  );

endinterface

// File: rtl/win_stat_counter.sv
// Saturating presented-window counter with synchronous clear.
module win_stat_counter
  import corr_win_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   inc,
  output logic [WIN_COUNT_W-1:0] count
);

  logic [WIN_COUNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIN_COUNT_W{1'b1}})) begin
      count_reg <= count_reg + WIN_COUNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/corr_window_ctrl.sv
// Sequencer for the correlation window shift register: decimated fill, present, flush.
// Define CORR_WIN_STATS_EN to count presented windows on win_count (else tied to 0).
module corr_window_ctrl
  import corr_win_pkg::*;
#(
  parameter int DEPTH = CORR_WIN_DEPTH,
  parameter int DECIM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  corr_window_ctrl_if.slave bus
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [FW-1:0] DEPTH_C    = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_ONE   = FW'(1);
  localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);
  localparam logic [DW-1:0] DECIM_ONE  = DW'(1);

  win_state_t          state_reg;
  logic [FW-1:0]       fill_cnt_reg;
  logic [FW-1:0]       flush_cnt_reg;
  logic [DW-1:0]       decim_cnt_reg;
  logic                in_ready_reg;
  logic                sr_we_reg;
  logic [NIBBLE_W-1:0] sr_wdata_reg;
  logic                win_valid_reg;
  logic                busy_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      fill_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      decim_cnt_reg <= '0;
      in_ready_reg  <= 1'b0;
      sr_we_reg     <= 1'b0;
      sr_wdata_reg  <= '0;
      win_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      sr_we_reg <= 1'b0;
      busy_reg  <= (state_reg != ST_IDLE);
      if (bus.flush) begin
        state_reg     <= ST_FLUSH;
        flush_cnt_reg <= FILL_ONE;
        sr_we_reg     <= 1'b1;
        sr_wdata_reg  <= '0;
        in_ready_reg  <= 1'b0;
        win_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (bus.start) begin
              state_reg     <= ST_ACCEPT;
              fill_cnt_reg  <= '0;
              decim_cnt_reg <= '0;
              in_ready_reg  <= 1'b1;
            end
          end
          ST_ACCEPT: begin
            // in_ready low here only during the write cycle of a priming nibble
            if (!in_ready_reg) begin
              state_reg <= ST_SETTLE;
            end else if (bus.in_valid) begin
              decim_cnt_reg <= (decim_cnt_reg == DECIM_LAST) ? '0 : decim_cnt_reg + DECIM_ONE;
              if (decim_cnt_reg == DECIM_LAST) begin
                sr_we_reg    <= 1'b1;
                sr_wdata_reg <= bus.in_data;
                if (fill_cnt_reg >= DEPTH_C - FILL_ONE) begin
                  fill_cnt_reg <= DEPTH_C;
                  in_ready_reg <= 1'b0;
                end else begin
                  fill_cnt_reg <= fill_cnt_reg + FILL_ONE;
                end
              end
            end
          end
          ST_SETTLE: begin
            state_reg     <= ST_PRESENT;
            win_valid_reg <= 1'b1;
          end
          ST_PRESENT: begin
            if (bus.win_ack) begin
              state_reg     <= ST_ACCEPT;
              win_valid_reg <= 1'b0;
              in_ready_reg  <= 1'b1;
            end
          end
          ST_FLUSH: begin
            if (flush_cnt_reg == DEPTH_C) begin
              state_reg    <= ST_IDLE;
              fill_cnt_reg <= '0;
            end else begin
              sr_we_reg     <= 1'b1;
              sr_wdata_reg  <= '0;
              flush_cnt_reg <= flush_cnt_reg + FILL_ONE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.sr_we     = sr_we_reg;
  assign bus.sr_wdata  = sr_wdata_reg;
  assign bus.win_valid = win_valid_reg;
  assign bus.busy      = busy_reg;

`ifdef CORR_WIN_STATS_EN
  logic stat_inc;
  logic flush_done;

  assign stat_inc   = (state_reg == ST_SETTLE) && !bus.flush;
  assign flush_done = (state_reg == ST_FLUSH) && (flush_cnt_reg == DEPTH_C) && !bus.flush;

  win_stat_counter u_stats (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_done),
    .inc   (stat_inc),
    .count (bus.win_count)
  );
`else
  assign bus.win_count = '0;
`endif

endmodule

// File: tb/tb_corr_window_ctrl.sv
// Self-checking bench: DECIM=1 and DECIM=4 instances against a transaction-level window model.
module tb_corr_window_ctrl;
  import corr_win_pkg::*;

`ifdef CORR_WIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int DEC_B = 4;
  localparam int WIN   = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  corr_window_ctrl_if bus_a();
  corr_window_ctrl_if bus_b();

  corr_window_ctrl #(.DEPTH(WIN), .DECIM(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  corr_window_ctrl #(.DEPTH(WIN), .DECIM(DEC_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // external shift register as seen by the correlator, plus observed writes
  logic [67:0] sr_a = '0;
  logic [67:0] sr_b = '0;
  logic [3:0]  wr_a[$];
  logic [3:0]  wr_b[$];

  // reference model: expected writes, written history, fill level, window count
  logic [3:0]  exp_wr_a[$];
  logic [3:0]  exp_wr_b[$];
  logic [3:0]  hist_a[$];
  logic [3:0]  hist_b[$];
  int          acc_cnt[2];
  int          fill_m[2];
  int          wc_m[2];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus_a.sr_we === 1'b1) begin
      wr_a.push_back(bus_a.sr_wdata);
      sr_a = {bus_a.sr_wdata, sr_a[67:4]};
    end
    if (bus_b.sr_we === 1'b1) begin
      wr_b.push_back(bus_b.sr_wdata);
      sr_b = {bus_b.sr_wdata, sr_b[67:4]};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  function automatic logic [67:0] exp_win(input bit sel);
    logic [67:0] w;
    int n;
    w = '0;
    n = sel ? hist_b.size() : hist_a.size();
    for (int k = 0; k < WIN; k++) begin
      if (n - WIN + k >= 0) w[4*k +: 4] = sel ? hist_b[n-WIN+k] : hist_a[n-WIN+k];
    end
    return w;
  endfunction

  function automatic logic [15:0] exp_wc(input bit sel);
    return STATS ? 16'(wc_m[sel]) : 16'h0000;
  endfunction

  task automatic model_write(input bit sel, input logic [3:0] d);
    if (sel) begin exp_wr_b.push_back(d); hist_b.push_back(d); end
    else     begin exp_wr_a.push_back(d); hist_a.push_back(d); end
    if (fill_m[sel] < WIN) fill_m[sel]++;
    if (fill_m[sel] == WIN && wc_m[sel] < 65535) wc_m[sel]++;
  endtask

  task automatic do_start(input bit sel);
    acc_cnt[sel] = 0;
    fill_m[sel] = 0;
    if (sel) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  // offer one nibble, wait (bounded) for acceptance, update the model
  task automatic send(input bit sel, input logic [3:0] d, input int gap, output int acc_cyc);
    int n;
    for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
    if (sel) begin bus_b.in_valid = 1'b1; bus_b.in_data = d; end
    else     begin bus_a.in_valid = 1'b1; bus_a.in_data = d; end
    n = 0;
    while (((sel ? bus_b.in_ready : bus_a.in_ready) !== 1'b1) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n >= 40) begin
      miscompares++;
      $display("FAIL send_timeout: dut=%0d in_ready low for %0d cycles, required high", sel, n);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    acc_cnt[sel]++;
    if (acc_cnt[sel] % (sel ? DEC_B : 1) == 0) model_write(sel, d);
    $display("xfer dut=%0d data=%h cyc=%0d", sel, d, acc_cyc);
  endtask

  task automatic win_profile(input bit sel, output logic [2:0] prof);
    prof[2] = sel ? bus_b.win_valid : bus_a.win_valid;
    @(posedge clk); #1;
    prof[1] = sel ? bus_b.win_valid : bus_a.win_valid;
    @(posedge clk); #1;
    prof[0] = sel ? bus_b.win_valid : bus_a.win_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.in_valid = 1'b1; bus_b.in_valid = 1'b1;
    bus_a.in_data = 4'h5;  bus_b.in_data = 4'h5;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus_a.in_ready, bus_b.in_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_in_ready: got %b required 00", {bus_a.in_ready, bus_b.in_ready});
    end
    vectors++;
    if ({bus_a.sr_we, bus_b.sr_we} !== 2'b00) begin
      miscompares++; $display("FAIL reset_sr_we: got %b required 00", {bus_a.sr_we, bus_b.sr_we});
    end
    vectors++;
    if ({bus_a.sr_wdata, bus_b.sr_wdata} !== 8'h00) begin
      miscompares++; $display("FAIL reset_sr_wdata: got %h required 00", {bus_a.sr_wdata, bus_b.sr_wdata});
    end
    vectors++;
    if ({bus_a.win_valid, bus_b.win_valid} !== 2'b00) begin
      miscompares++; $display("FAIL reset_win_valid: got %b required 00", {bus_a.win_valid, bus_b.win_valid});
    end
    vectors++;
    if ({bus_a.busy, bus_b.busy} !== 2'b00) begin
      miscompares++; $display("FAIL reset_busy: got %b required 00", {bus_a.busy, bus_b.busy});
    end
    vectors++;
    if ({bus_a.win_count, bus_b.win_count} !== 32'h0) begin
      miscompares++; $display("FAIL reset_win_count: got %h required 0", {bus_a.win_count, bus_b.win_count});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus_a.in_ready, bus_b.in_ready, bus_a.sr_we} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_no_start: cycle %0d ready/we=%b required 000", i, {bus_a.in_ready, bus_b.in_ready, bus_a.sr_we});
      end
    end
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
  endtask

  task automatic test_fill();
    int c, c0, c1;
    logic [2:0] prof;
    c0 = 0; c1 = 0;
    wr_a.delete(); exp_wr_a.delete();
    do_start(0);
    vectors++;
    if (bus_a.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL start_ready: got %b required 1", bus_a.in_ready);
    end
    for (int k = 0; k < WIN; k++) begin
      send(0, 4'((k + 1) % 16), 0, c);
      if (k == 0) c0 = c;
      c1 = c;
    end
    vectors++;
    if (c1 - c0 != WIN - 1) begin
      miscompares++; $display("FAIL fill_back_to_back: span %0d cycles required %0d", c1 - c0, WIN - 1);
    end
    win_profile(0, prof);
    vectors++;
    if (prof !== 3'b001) begin
      miscompares++; $display("FAIL first_window_latency: win_valid profile %b required 001", prof);
    end
    vectors++;
    if (wr_a.size() != exp_wr_a.size()) begin
      miscompares++; $display("FAIL fill_write_count: got %0d required %0d", wr_a.size(), exp_wr_a.size());
    end else begin
      foreach (wr_a[i]) begin
        vectors++;
        if (wr_a[i] !== exp_wr_a[i]) begin
          miscompares++; $display("FAIL fill_write_%0d: got %h required %h", i, wr_a[i], exp_wr_a[i]);
        end
      end
    end
    vectors++;
    if (sr_a[3:0] !== 4'h1 || sr_a !== exp_win(0)) begin
      miscompares++; $display("FAIL fill_window: got %h required %h", sr_a, exp_win(0));
    end
    vectors++;
    if (bus_a.win_count !== exp_wc(0)) begin
      miscompares++; $display("FAIL fill_win_count: got %0d required %0d", bus_a.win_count, exp_wc(0));
    end
  endtask

  task automatic test_present_hold();
    int c;
    logic [2:0] prof;
    bus_a.in_valid = 1'b1;
    bus_a.in_data = 4'($urandom);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({bus_a.in_ready, bus_a.win_valid} !== 2'b01) begin
        miscompares++; $display("FAIL hold_present_%0d: ready/valid %b required 01", i, {bus_a.in_ready, bus_a.win_valid});
      end
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b0;
    bus_a.win_ack = 1'b1;
    @(posedge clk); #1;
    bus_a.win_ack = 1'b0;
    vectors++;
    if ({bus_a.in_ready, bus_a.win_valid} !== 2'b10) begin
      miscompares++; $display("FAIL ack_to_accept: ready/valid %b required 10", {bus_a.in_ready, bus_a.win_valid});
    end
    wr_a.delete(); exp_wr_a.delete();
    send(0, 4'hA, 0, c);
    win_profile(0, prof);
    vectors++;
    if (prof !== 3'b001) begin
      miscompares++; $display("FAIL repesent_latency: win_valid profile %b required 001", prof);
    end
    vectors++;
    if (wr_a.size() != 1 || wr_a[0] !== 4'hA) begin
      miscompares++; $display("FAIL repesent_write: got %0d writes first %h required 1 write of a", wr_a.size(), wr_a[0]);
    end
    vectors++;
    if (bus_a.win_count !== exp_wc(0)) begin
      miscompares++; $display("FAIL repesent_win_count: got %0d required %0d", bus_a.win_count, exp_wc(0));
    end
    vectors++;
    if (sr_a !== exp_win(0)) begin
      miscompares++; $display("FAIL repesent_window: got %h required %h", sr_a, exp_win(0));
    end
  endtask

  task automatic test_throughput();
    int c, prev;
    logic [2:0] prof;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      bus_a.win_ack = 1'b1;
      @(posedge clk); #1;
      bus_a.win_ack = 1'b0;
      send(0, 4'($urandom), 0, c);
      if (k > 0) begin
        vectors++;
        if (c - prev != 4) begin
          miscompares++; $display("FAIL throughput_%0d: spacing %0d cycles required 4", k, c - prev);
        end
      end
      prev = c;
      win_profile(0, prof);
      vectors++;
      if (prof !== 3'b001 || sr_a !== exp_win(0)) begin
        miscompares++; $display("FAIL throughput_window_%0d: profile %b window %h required 001 %h", k, prof, sr_a, exp_win(0));
      end
    end
    vectors++;
    if (bus_a.win_count !== exp_wc(0)) begin
      miscompares++; $display("FAIL throughput_win_count: got %0d required %0d", bus_a.win_count, exp_wc(0));
    end
  endtask

  task automatic test_flush_vs_ack();
    wr_a.delete();
    bus_a.flush = 1'b1;
    bus_a.win_ack = 1'b1;
    @(posedge clk); #1;
    bus_a.flush = 1'b0;
    bus_a.win_ack = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      vectors++;
      if ({bus_a.sr_we, bus_a.sr_wdata, bus_a.in_ready, bus_a.win_valid} !== 7'b1_0000_00) begin
        miscompares++;
        $display("FAIL flush_cycle_%0d: we/wdata/ready/valid %b required 1000000", i,
                 {bus_a.sr_we, bus_a.sr_wdata, bus_a.in_ready, bus_a.win_valid});
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({bus_a.sr_we, bus_a.busy} !== 2'b01) begin
      miscompares++; $display("FAIL flush_end: we/busy %b required 01", {bus_a.sr_we, bus_a.busy});
    end
    @(posedge clk); #1;
    for (int i = 0; i < WIN; i++) hist_a.push_back(4'h0);
    fill_m[0] = 0;
    wc_m[0] = 0;
    vectors++;
    if (bus_a.busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_busy_fall: got %b required 0", bus_a.busy);
    end
    vectors++;
    if (wr_a.size() != WIN || sr_a !== exp_win(0)) begin
      miscompares++; $display("FAIL flush_writes: %0d writes window %h required %0d zero writes", wr_a.size(), sr_a, WIN);
    end
    vectors++;
    if (bus_a.win_count !== exp_wc(0)) begin
      miscompares++; $display("FAIL flush_win_count: got %0d required %0d", bus_a.win_count, exp_wc(0));
    end
    @(posedge clk); #1;
    vectors++;
    if ({bus_a.in_ready, bus_a.sr_we} !== 2'b00) begin
      miscompares++; $display("FAIL flush_idle: ready/we %b required 00", {bus_a.in_ready, bus_a.sr_we});
    end
  endtask

  task automatic test_decim();
    int c;
    logic [2:0] prof;
    wr_b.delete(); exp_wr_b.delete();
    do_start(1);
    for (int k = 0; k < 8; k++) send(1, 4'(k), 0, c);
    @(posedge clk); #1;
    vectors++;
    if (wr_b.size() != 2 || wr_b[0] !== 4'h3 || wr_b[1] !== 4'h7) begin
      miscompares++; $display("FAIL decim_first_writes: %0d writes %h %h required 2 writes 3 7", wr_b.size(), wr_b[0], wr_b[1]);
    end
    for (int k = 0; k < 60; k++) send(1, 4'($urandom), int'($urandom_range(0, 2)), c);
    win_profile(1, prof);
    vectors++;
    if (prof !== 3'b001) begin
      miscompares++; $display("FAIL decim_window_latency: win_valid profile %b required 001", prof);
    end
    vectors++;
    if (wr_b.size() != exp_wr_b.size()) begin
      miscompares++; $display("FAIL decim_write_count: got %0d required %0d", wr_b.size(), exp_wr_b.size());
    end else begin
      foreach (wr_b[i]) begin
        vectors++;
        if (wr_b[i] !== exp_wr_b[i]) begin
          miscompares++; $display("FAIL decim_write_%0d: got %h required %h", i, wr_b[i], exp_wr_b[i]);
        end
      end
    end
    vectors++;
    if (sr_b !== exp_win(1)) begin
      miscompares++; $display("FAIL decim_window: got %h required %h", sr_b, exp_win(1));
    end
    vectors++;
    if (bus_b.win_count !== exp_wc(1)) begin
      miscompares++; $display("FAIL decim_win_count: got %0d required %0d", bus_b.win_count, exp_wc(1));
    end
  endtask

  task automatic test_flush_restart();
    int n;
    wr_b.delete();
    bus_b.flush = 1'b1;
    @(posedge clk); #1;
    bus_b.flush = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus_b.flush = 1'b1;
    @(posedge clk); #1;
    bus_b.flush = 1'b0;
    n = 0;
    while (bus_b.busy === 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < WIN; i++) hist_b.push_back(4'h0);
    fill_m[1] = 0;
    wc_m[1] = 0;
    vectors++;
    if (n != WIN + 1) begin
      miscompares++; $display("FAIL restart_busy_fall: %0d cycles after restart required %0d", n, WIN + 1);
    end
    vectors++;
    if (wr_b.size() != 5 + WIN) begin
      miscompares++; $display("FAIL restart_write_count: got %0d required %0d", wr_b.size(), 5 + WIN);
    end
    vectors++;
    if (sr_b !== exp_win(1) || bus_b.win_count !== exp_wc(1)) begin
      miscompares++; $display("FAIL restart_clear: window %h count %0d required 0 %0d", sr_b, bus_b.win_count, exp_wc(1));
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [2:0] prof;
    do_start(0);
    for (int k = 0; k < 9; k++) send(0, 4'($urandom), 0, c);
    rst_n = 1'b0;
    @(posedge clk); #1;
    wc_m[0] = 0;
    wc_m[1] = 0;
    vectors++;
    if ({bus_a.in_ready, bus_a.sr_we, bus_a.busy, bus_a.win_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid: ready/we/busy/valid %b required 0000", {bus_a.in_ready, bus_a.sr_we, bus_a.busy, bus_a.win_valid});
    end
    vectors++;
    if (bus_a.win_count !== exp_wc(0)) begin
      miscompares++; $display("FAIL reset_mid_win_count: got %0d required %0d", bus_a.win_count, exp_wc(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(0);
    for (int k = 0; k < WIN; k++) send(0, 4'($urandom), 0, c);
    win_profile(0, prof);
    vectors++;
    if (prof !== 3'b001) begin
      miscompares++; $display("FAIL refill_latency: win_valid profile %b required 001", prof);
    end
    vectors++;
    if (sr_a !== exp_win(0) || bus_a.win_count !== exp_wc(0)) begin
      miscompares++; $display("FAIL refill_window: window %h count %0d required %h %0d", sr_a, bus_a.win_count, exp_win(0), exp_wc(0));
    end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.win_ack = 1'b0;
    bus_b.start = 1'b0; bus_b.flush = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.win_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin acc_cnt[i] = 0; fill_m[i] = 0; wc_m[i] = 0; end
    test_reset();
    test_fill();
    test_present_hold();
    test_throughput();
    test_flush_vs_ack();
    test_decim();
    test_flush_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/corr_window_ctrl.md
# corr_window_ctrl

Sequencer for the 17-symbol I/Q correlation window shift register in the receive path. It accepts 4-bit I/Q symbol nibbles from the demodulator over a valid/ready stream and applies optional decimation. It drives the shift register's write enable and data, tracks when the window is fully primed, and presents each new window to the correlator with a valid/ack handshake. It also provides a flush sequence that zeroes the register, which itself has no reset.

## Interface
- DEPTH, 17, nibbles held by the shift register (68 bits / 4)
- DECIM, 1, write one of every DECIM accepted nibbles (DECIM ≥ 1)
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- START  in  1  pulse; begin filling (honoured in IDLE only)
- FLUSH  in  1  pulse; zero the window (honoured in any state)
- IN_VALID  in  1  nibble available
- IN_DATA  in  4  {I[1:0], Q[1:0]} symbol nibble
- IN_READY  out  1  nibble accepted when IN_VALID & IN_READY
- SR_WE  out  1  shift register write enable
- SR_WDATA  out  4  shift register write data
- WIN_VALID  out  1  window primed and updated; RDATA_I/RDATA_Q stable
- WIN_ACK  in  1  correlator consumed current window
- BUSY  out  1  state ≠ IDLE
- WIN_COUNT  out  16  windows presented (see Configuration)

## Operation
- States: IDLE, ACCEPT, SETTLE, PRESENT, FLUSH.
- Reset value of every output: 0. Reset state is IDLE. fill_cnt, decim_cnt and WIN_COUNT are 0.
- IDLE: IN_READY=0. START moves to ACCEPT with fill_cnt=0 and decim_cnt=0.
- ACCEPT: IN_READY=1. On acceptance, decim_cnt advances modulo DECIM. Only the nibble accepted when decim_cnt==DECIM-1 is written; all other accepted nibbles are discarded.
- A written nibble registers SR_WE=1 and SR_WDATA=IN_DATA for exactly one cycle. fill_cnt increments, saturating at DEPTH.
- After a write: if fill_cnt reaches DEPTH, the state goes to SETTLE. Otherwise it stays in ACCEPT.
- SETTLE: one cycle, IN_READY=0, lets the shift register capture the write. Always goes to PRESENT.
- PRESENT: WIN_VALID=1 and IN_READY=0. WIN_ACK returns the state to ACCEPT (window saturated, so every later write re-presents). WIN_VALID stays high until WIN_ACK, so the correlator has no timeout.
- FLUSH: entered from any state on FLUSH, including FLUSH itself, which restarts the sequence.
  - Issues DEPTH consecutive cycles of SR_WE=1, SR_WDATA=0 with IN_READY=0 and WIN_VALID=0.
  - Then goes to IDLE with fill_cnt=0.
- Priority, highest first: RST_N low, FLUSH, WIN_ACK/START. START outside IDLE is ignored. WIN_ACK outside PRESENT is ignored.
- Reset mid-operation returns the block to IDLE immediately with no write issued. Register contents are undefined, so software issues FLUSH.
- Counter widths: fill_cnt uses $clog2(DEPTH+1) bits and decim_cnt uses $clog2(DECIM) bits (min 1).

## Timing
- IN_READY is a registered decode of the state. It does not depend combinationally on IN_VALID.
- A nibble accepted at edge t produces SR_WE=1 during cycle t..t+1. The shift register captures it at edge t+1.
- If that write primes the window, SETTLE occupies the next cycle and WIN_VALID rises after edge t+2. First-window latency is 2 cycles after the last accept.
- With a saturated window and WIN_ACK asserted the first PRESENT cycle, sustained throughput is 1 nibble per 4 cycles (ACCEPT, write, SETTLE, PRESENT).
- FLUSH asserted at edge t makes SR_WE high for cycles t+1..t+DEPTH. BUSY falls after edge t+DEPTH+1.

## Configuration
- CORR_WIN_STATS_EN defined: WIN_COUNT increments on each PRESENT entry, saturates at 16'hFFFF, and clears on reset and on FLUSH completion.
- CORR_WIN_STATS_EN undefined: WIN_COUNT is tied to 0 and no counter logic is synthesised.

## Structure
- Package corr_win_pkg holds the state enum (IDLE, ACCEPT, SETTLE, PRESENT, FLUSH), CORR_WIN_DEPTH=17, and the nibble width constant 4.
- Sub-module win_stat_counter is a 16-bit saturating counter with clear, instantiated only under CORR_WIN_STATS_EN.
- The FSM, fill and decim counters, and the registered SR_WE/SR_WDATA stay in corr_window_ctrl.

## Test plan
- Reset with IN_VALID=1 → all outputs 0, state IDLE; IN_READY stays 0 until START.
- START, then 17 nibbles 4'h1..4'hF,4'h0,4'h1 back-to-back, DECIM=1 → 17 SR_WE pulses with matching SR_WDATA; WIN_VALID rises 2 cycles after the 17th accept; first nibble at RDATA lsb pair.
- In PRESENT, hold WIN_ACK low 10 cycles with IN_VALID=1 → IN_READY=0 throughout. Then ACK and feed 4'hA → one write, WIN_VALID again after SETTLE, WIN_COUNT=2 (stats build).
- DECIM=4, feed 8 nibbles 0..7 → exactly 2 writes, SR_WDATA=3 then 7; fill_cnt=2.
- FLUSH asserted in PRESENT simultaneously with WIN_ACK → FLUSH wins; 17 cycles SR_WE=1/SR_WDATA=0; RDATA_I=RDATA_Q=0; IDLE; WIN_COUNT=0.
- RST_N low mid-fill after 9 writes → next cycle IDLE, SR_WE=0. START plus 17 nibbles → WIN_VALID only after a full 17 new writes.
